melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Sequencer that sits directly in front of the buzzer tone generator and drives its 4-bit note code. In auto-play it walks a song stored in an external synchronous ROM, where each entry is a note plus a duration in beats. It holds each note for its duration, inserts a short silent gap between notes, and stops at an end marker or at the end of the table. When idle it passes the live keyboard note through, so the buzzer is shared between manual play and auto-play, with auto-play taking priority.

## Interface
- TICKS_PER_BEAT, 25_000_000, clk cycles per beat (≥1)
- GAP_TICKS, 2_500_000, silent cycles after every note (0 = no gap)
- SONG_LEN, 16, max ROM entries per song (2..256)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- play  input  1  start request, sampled each edge
- stop  input  1  abort request, sampled each edge
- key_note  input  4  live manual note: 0 = rest, 1..7 = do..si
- rom_addr  output  8  song ROM address, registered
- rom_data  input  8  {note[7:4], beats[3:0]}, valid one cycle after rom_addr changes
- note_out  output  4  note code to the buzzer, registered
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse on normal song completion
- index  output  8  current entry index

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE:
  - note_out ← sanitize(key_note) every cycle. sanitize maps 8..15 to 0.
  - play=1 and stop=0 → index←0, rom_addr←0, go to FETCH.
- FETCH: one cycle, for ROM latency. Go to LOAD.
- LOAD: decode rom_data.
  - note field = 4'hF → go to DONE. note_out←0.
  - Otherwise note_out←sanitize(note). Load beat_cnt←(beats==0 ? 1 : beats) and tick_cnt←0, then go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICKS_PER_BEAT-1. On wrap, beat_cnt decrements.
  - On the last tick of the last beat: if GAP_TICKS>0, go to GAP with note_out←0. Otherwise go to ADVANCE.
- GAP: note_out=0 for GAP_TICKS cycles, then ADVANCE.
- ADVANCE (a transition, not a state):
  - index = SONG_LEN-1 → DONE.
  - Otherwise index++ and rom_addr++, go to FETCH.
- DONE: done=1 for one cycle, note_out=0, go to IDLE.
- stop=1 in any non-IDLE state → IDLE on the next edge. note_out←0, done stays 0, index and rom_addr are left unchanged.
- stop and play both high in IDLE: stop wins, stay in IDLE.
- play while busy is ignored; a song cannot restart mid-play.
- key_note is ignored while busy.
- Counters: tick_cnt is 32-bit. beat_cnt is 4-bit. index is 8-bit and never exceeds SONG_LEN-1.

## Timing
- Reset (rst_n=0, async) values:
  - state = IDLE
  - note_out = 0, rom_addr = 0, index = 0
  - busy = 0, done = 0
  - all counters = 0
- Reset mid-song returns to IDLE immediately, with no done pulse.
- Start latency: play sampled at edge N gives busy=1 and rom_addr=0 after N, LOAD after N+1, and the first note on note_out after N+2.
- Per-entry period: 2 + beats·TICKS_PER_BEAT + GAP_TICKS cycles.
  - note_out holds the note for exactly beats·TICKS_PER_BEAT cycles.
  - It is then 0 for GAP_TICKS cycles.
  - It also holds the prior value (0 after a gap) during FETCH/LOAD.
- done pulses for exactly one cycle, on the edge after the terminating LOAD or ADVANCE. busy falls on the following edge.
- IDLE pass-through latency: 1 cycle, key_note to note_out.

## Test plan
Parameters for all scenarios: TICKS_PER_BEAT=4, GAP_TICKS=2, SONG_LEN=4.

- ROM {0x12, 0x31, 0xF0}, pulse play → note_out = 1 for 8 cycles, 0 for 2, 3 for 4, 0 for 2. Then done pulses once, busy falls, and total busy time matches the period formula.
- ROM {0x11, 0x21, 0x31, 0x41, 0x51}, no terminator → exactly notes 1..4 play, index peaks at 3, done pulses, and note 5 never appears.
- ROM entry 0x50 (beats=0) and entry 0x91 → the first plays note 5 for 4 cycles; note 9 is output as 0 for 4 cycles.
- Stop asserted mid-note on entry 1 → IDLE next edge, note_out=0, no done pulse. A new play restarts from index 0.
- IDLE with key_note=3 → note_out=3 one cycle later. With key_note=9 → note_out=0. During play, changing key_note has no effect, and play re-pulses are ignored.
- rst_n pulled low mid-PLAY → all outputs return to reset values immediately. After release the block stays in IDLE until play.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a song ROM of {note, beats} entries and drives the
// buzzer note code, falling back to the live keyboard note when idle.
module melody_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000,
  parameter int unsigned SONG_LEN       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       stop,
  input  logic [3:0] key_note,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] note_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] index
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [31:0] TICK_LAST  = 32'(TICKS_PER_BEAT - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_TICKS - 1);
  localparam logic [7:0]  INDEX_LAST = 8'(SONG_LEN - 1);
  localparam logic [3:0]  NOTE_END   = 4'hF;

  state_t      state, state_next;
  logic [3:0]  note_next;
  logic [7:0]  addr_next, index_next;
  logic [3:0]  beat_cnt, beat_next;
  logic [31:0] tick_cnt, tick_next;
  logic        advance;

  // Codes above 7 are not playable notes and are silenced.
  function automatic logic [3:0] sanitize(input logic [3:0] n);
    return n[3] ? 4'd0 : n;
  endfunction

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      note_out <= '0;
      rom_addr <= '0;
      index    <= '0;
      beat_cnt <= '0;
      tick_cnt <= '0;
    end else begin
      state    <= state_next;
      note_out <= note_next;
      rom_addr <= addr_next;
      index    <= index_next;
      beat_cnt <= beat_next;
      tick_cnt <= tick_next;
    end
  end

  // Next-state and next-datapath logic; ADVANCE is folded in after the case.
  always_comb begin
    state_next = state;
    note_next  = note_out;
    addr_next  = rom_addr;
    index_next = index;
    beat_next  = beat_cnt;
    tick_next  = tick_cnt;
    advance    = 1'b0;

    unique case (state)
      S_IDLE: begin
        note_next = sanitize(key_note);
        if (play && !stop) begin
          index_next = '0;
          addr_next  = '0;
          state_next = S_FETCH;
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        if (rom_data[7:4] == NOTE_END) begin
          note_next  = '0;
          state_next = S_DONE;
        end else begin
          note_next  = sanitize(rom_data[7:4]);
          beat_next  = (rom_data[3:0] == 4'd0) ? 4'd1 : rom_data[3:0];
          tick_next  = '0;
          state_next = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_cnt == TICK_LAST) begin
          tick_next = '0;
          if (beat_cnt == 4'd1) begin
            if (GAP_TICKS > 0) begin
              note_next  = '0;
              state_next = S_GAP;
            end else begin
              advance = 1'b1;
            end
          end else begin
            beat_next = beat_cnt - 4'd1;
          end
        end else begin
          tick_next = tick_cnt + 32'd1;
        end
      end
      S_GAP: begin
        if (tick_cnt == GAP_LAST) begin
          tick_next = '0;
          advance   = 1'b1;
        end else begin
          tick_next = tick_cnt + 32'd1;
        end
      end
      S_DONE: begin
        note_next  = '0;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    if (advance) begin
      if (index == INDEX_LAST) begin
        note_next  = '0;
        state_next = S_DONE;
      end else begin
        index_next = index + 8'd1;
        addr_next  = rom_addr + 8'd1;
        state_next = S_FETCH;
      end
    end

    // Abort overrides everything except position, which is left where it was.
    if (stop && state != S_IDLE) begin
      state_next = S_IDLE;
      note_next  = '0;
      index_next = index;
      addr_next  = rom_addr;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer (TICKS_PER_BEAT=4,
// GAP_TICKS=2, SONG_LEN=4) with a one-cycle-latency ROM model.
module tb_melody_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play, stop;
  logic [3:0] key_note;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] note_out;
  logic       busy, done;
  logic [7:0] index;

  logic [7:0] rom [0:255];

  int checks   = 0;
  int failures = 0;

  logic [3:0] cap_note [0:255];
  logic       cap_busy [0:255];
  logic       cap_done [0:255];
  logic [7:0] cap_idx  [0:255];
  int         cap_len;

  melody_sequencer #(
    .TICKS_PER_BEAT(4),
    .GAP_TICKS(2),
    .SONG_LEN(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .play(play),
    .stop(stop),
    .key_note(key_note),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .note_out(note_out),
    .busy(busy),
    .done(done),
    .index(index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic record(input int k);
    cap_note[k] = note_out;
    cap_busy[k] = busy;
    cap_done[k] = done;
    cap_idx[k]  = index;
  endtask

  // Pulse play, then sample every cycle until busy falls (bounded).
  task automatic run_song(input bit disturb);
    play = 1'b1;
    tick();
    play = 1'b0;
    cap_len = 0;
    record(0);
    for (int k = 1; k < 200; k++) begin
      if (disturb) begin
        key_note = 4'(k);
        play     = (k % 3 == 0);
      end
      tick();
      record(k);
      if (!busy) begin
        cap_len = k + 1;
        break;
      end
    end
    play     = 1'b0;
    key_note = 4'd0;
  endtask

  task automatic test_reset;
    checks++;
    if (note_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        index !== 8'd0 || rom_addr !== 8'd0) begin
      failures++;
      $display("FAIL reset note=%0h busy=%b done=%b idx=%0h addr=%0h exp all 0",
               note_out, busy, done, index, rom_addr);
    end
  endtask

  // Checks a capture against the {0x12,0x31,0xF0} song timeline.
  task automatic check_song1(input string tag);
    logic [3:0] en;
    checks++;
    if (cap_len !== 24) begin
      failures++;
      $display("FAIL %s_len got=%0d exp=24", tag, cap_len);
    end
    if (cap_len == 24) begin
      for (int k = 0; k < 24; k++) begin
        en = (k >= 2 && k <= 9) ? 4'd1 : (k >= 14 && k <= 17) ? 4'd3 : 4'd0;
        checks++;
        if (cap_note[k] !== en || cap_busy[k] !== (k <= 22) || cap_done[k] !== (k == 22)) begin
          failures++;
          $display("FAIL %s_cycle%0d note=%0h busy=%b done=%b exp note=%0h busy=%b done=%b",
                   tag, k, cap_note[k], cap_busy[k], cap_done[k], en, (k <= 22), (k == 22));
        end
      end
    end
  endtask

  task automatic test_basic_song;
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h31; rom[2] = 8'hF0;
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++;
    if (busy !== 1'b1 || rom_addr !== 8'd0 || index !== 8'd0) begin
      failures++;
      $display("FAIL start_latency busy=%b addr=%0h idx=%0h exp 1/0/0", busy, rom_addr, index);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    run_song(1'b0);
    check_song1("song1");
  endtask

  task automatic test_table_end;
    logic [3:0] en;
    logic [7:0] ei;
    logic [7:0] peak;
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h31; rom[3] = 8'h41; rom[4] = 8'h51;
    run_song(1'b0);
    checks++;
    if (cap_len !== 34) begin
      failures++;
      $display("FAIL table_end_len got=%0d exp=34", cap_len);
    end
    if (cap_len == 34) begin
      peak = 8'd0;
      for (int k = 0; k < 34; k++) begin
        en = (k < 32 && (k % 8) >= 2 && (k % 8) <= 5) ? 4'(k / 8 + 1) : 4'd0;
        ei = (k < 32) ? 8'(k / 8) : 8'd3;
        if (cap_idx[k] > peak) peak = cap_idx[k];
        checks++;
        if (cap_note[k] !== en || cap_idx[k] !== ei || cap_done[k] !== (k == 32)) begin
          failures++;
          $display("FAIL table_end_cycle%0d note=%0h idx=%0h done=%b exp note=%0h idx=%0h done=%b",
                   k, cap_note[k], cap_idx[k], cap_done[k], en, ei, (k == 32));
        end
      end
      checks++;
      if (peak !== 8'd3) begin
        failures++;
        $display("FAIL table_end_peak got=%0h exp=3", peak);
      end
    end
  endtask

  task automatic test_sanitize_song;
    logic [3:0] en;
    clear_rom();
    rom[0] = 8'h50; rom[1] = 8'h91; rom[2] = 8'hF0;
    run_song(1'b0);
    checks++;
    if (cap_len !== 20) begin
      failures++;
      $display("FAIL sanitize_len got=%0d exp=20", cap_len);
    end
    if (cap_len == 20) begin
      for (int k = 0; k < 20; k++) begin
        en = (k >= 2 && k <= 5) ? 4'd5 : 4'd0;
        checks++;
        if (cap_note[k] !== en || cap_done[k] !== (k == 18)) begin
          failures++;
          $display("FAIL sanitize_cycle%0d note=%0h done=%b exp note=%0h done=%b",
                   k, cap_note[k], cap_done[k], en, (k == 18));
        end
      end
    end
  endtask

  task automatic test_stop;
    logic saw_done;
    clear_rom();
    rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h31; rom[3] = 8'h41;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (11) tick();
    checks++;
    if (note_out !== 4'd2 || index !== 8'd1) begin
      failures++;
      $display("FAIL stop_pre note=%0h idx=%0h exp 2/1", note_out, index);
    end
    key_note = 4'd6;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || note_out !== 4'd0 || done !== 1'b0 ||
        index !== 8'd1 || rom_addr !== 8'd1) begin
      failures++;
      $display("FAIL stop_abort busy=%b note=%0h done=%b idx=%0h addr=%0h exp 0/0/0/1/1",
               busy, note_out, done, index, rom_addr);
    end
    saw_done = 1'b0;
    repeat (4) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (note_out !== 4'd6 || busy !== 1'b0 || saw_done !== 1'b0) begin
      failures++;
      $display("FAIL stop_after note=%0h busy=%b done_seen=%b exp 6/0/0", note_out, busy, saw_done);
    end
    play = 1'b1;
    stop = 1'b1;
    tick();
    play = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_wins busy=%b exp 0", busy);
    end
    key_note = 4'd0;
    play = 1'b1;
    tick();
    play = 1'b0;
    checks++;
    if (busy !== 1'b1 || index !== 8'd0 || rom_addr !== 8'd0) begin
      failures++;
      $display("FAIL restart busy=%b idx=%0h addr=%0h exp 1/0/0", busy, index, rom_addr);
    end
    tick();
    tick();
    checks++;
    if (note_out !== 4'd1) begin
      failures++;
      $display("FAIL restart_note got=%0h exp=1", note_out);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_passthrough;
    key_note = 4'd3;
    tick();
    checks++;
    if (note_out !== 4'd3) begin
      failures++;
      $display("FAIL pass_key3 got=%0h exp=3", note_out);
    end
    key_note = 4'd9;
    tick();
    checks++;
    if (note_out !== 4'd0) begin
      failures++;
      $display("FAIL pass_key9 got=%0h exp=0", note_out);
    end
    key_note = 4'd7;
    tick();
    checks++;
    if (note_out !== 4'd7) begin
      failures++;
      $display("FAIL pass_key7 got=%0h exp=7", note_out);
    end
    key_note = 4'd0;
    tick();
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h31; rom[2] = 8'hF0;
    run_song(1'b1);
    check_song1("busy_ignore");
  endtask

  task automatic test_async_reset;
    clear_rom();
    rom[0] = 8'h12; rom[1] = 8'h31; rom[2] = 8'hF0;
    key_note = 4'd0;
    play = 1'b1;
    tick();
    play = 1'b0;
    repeat (15) tick();
    checks++;
    if (note_out !== 4'd3 || index !== 8'd1 || rom_addr !== 8'd1) begin
      failures++;
      $display("FAIL rst_pre note=%0h idx=%0h addr=%0h exp 3/1/1", note_out, index, rom_addr);
    end
    #2;
    rst_n = 1'b0;
    #1;
    test_reset();
    #2;
    rst_n = 1'b1;
    key_note = 4'd4;
    tick();
    checks++;
    if (note_out !== 4'd4 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle note=%0h busy=%b exp 4/0", note_out, busy);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL rst_stay busy=%b done=%b exp 0/0", busy, done);
    end
    key_note = 4'd0;
  endtask

  initial begin
    rst_n    = 1'b0;
    play     = 1'b0;
    stop     = 1'b0;
    key_note = 4'd0;
    clear_rom();
    #2;
    test_reset();
    #10;
    rst_n = 1'b1;
    tick();
    test_basic_song();
    test_table_end();
    test_sanitize_song();
    test_stop();
    test_passthrough();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
